// File: rtl/life_sequencer_if.sv
// Key inputs, rate select and cell-array control outputs of life_sequencer.
// LIFE_STILL_DETECT_EN adds grid_changed (in) and stable (out).
interface life_sequencer_if #(
  parameter int ROWS  = 16,
  parameter int COLS  = 16,
  parameter int GEN_W = 16
);
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);

  logic             key_run, key_step, key_clear, key_toggle;
  logic             key_up, key_down, key_left, key_right;
  logic [1:0]       speed;
  logic             step_en, clear_cells, seed_we, running;
  logic [RW-1:0]    seed_row, cursor_row;
  logic [CW-1:0]    seed_col, cursor_col;
  logic [GEN_W-1:0] gen_count;
`ifdef LIFE_STILL_DETECT_EN
  logic             grid_changed, stable;
`endif

  modport master (
    output key_run, key_step, key_clear, key_toggle,
    output key_up, key_down, key_left, key_right, speed,
`ifdef LIFE_STILL_DETECT_EN
    output grid_changed, input stable,
`endif
    input  step_en, clear_cells, seed_we, running,
    input  seed_row, seed_col, cursor_row, cursor_col, gen_count
  );

  modport slave (
    input  key_run, key_step, key_clear, key_toggle,
    input  key_up, key_down, key_left, key_right, speed,
`ifdef LIFE_STILL_DETECT_EN
    input  grid_changed, output stable,
`endif
    output step_en, clear_cells, seed_we, running,
    output seed_row, seed_col, cursor_row, cursor_col, gen_count
  );
endinterface

// File: rtl/life_sequencer.sv
// Game of Life generation controller: run/pause/step/clear FSM, rate divider, seed cursor.
// Optional still-life auto-pause under LIFE_STILL_DETECT_EN.
module life_sequencer #(
  parameter int ROWS        = 16,
  parameter int COLS        = 16,
  parameter int TICK_PERIOD = 25_000_000,
  parameter int GEN_W       = 16
) (
  input logic            Clock,
  input logic            reset,
  life_sequencer_if.slave bus
);
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam int DW = $clog2(TICK_PERIOD);
  localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);

  typedef enum logic [1:0] {PAUSE, RUN, STEP, CLEAR} state_t;
  typedef enum logic [2:0] {K_NONE, K_CLEAR, K_RUN, K_STEP, K_TOGGLE, K_MOVE} key_t;

  state_t           state, state_nxt;
  key_t             key;
  logic [DW-1:0]    div, reload;
  logic             tick, still_hit;
  logic             step_nxt, clear_nxt, seed_nxt, move_ok, reload_div, run_entry;
  logic             tog_q;
  logic             step_r, clear_r, seed_r, running_r;
  logic [RW-1:0]    row_r, row_nxt, srow_r;
  logic [CW-1:0]    col_r, col_nxt, scol_r;
  logic [GEN_W-1:0] gen_r;

  assign reload = DW'((TICK_PERIOD >> bus.speed) - 1);
  assign tick   = (state == RUN) && (div == '0);

  // Only the highest-priority key on an edge is considered; a winning key the
  // current state ignores still swallows the lower ones.
  always_comb begin
    key = K_NONE;
    if (bus.key_clear)       key = K_CLEAR;
    else if (bus.key_run)    key = K_RUN;
    else if (bus.key_step)   key = K_STEP;
    else if (bus.key_toggle) key = K_TOGGLE;
    else if (bus.key_up || bus.key_down || bus.key_left || bus.key_right) key = K_MOVE;
  end

`ifdef LIFE_STILL_DETECT_EN
  logic chk, stable_r;
  assign still_hit = chk && !bus.grid_changed;
`else
  assign still_hit = 1'b0;
`endif

  always_ff @(posedge Clock) begin
    if (reset) state <= PAUSE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      PAUSE: begin
        if (key == K_CLEAR)     state_nxt = CLEAR;
        else if (key == K_RUN)  state_nxt = RUN;
        else if (key == K_STEP) state_nxt = STEP;
      end
      RUN: begin
        if (key == K_CLEAR)                  state_nxt = CLEAR;
        else if (key == K_RUN || still_hit)  state_nxt = PAUSE;
      end
      default: state_nxt = PAUSE;
    endcase
  end

  always_comb begin
    step_nxt   = (state == STEP) || (tick && state_nxt == RUN);
    clear_nxt  = (state == CLEAR);
    seed_nxt   = (state == PAUSE) && (key == K_TOGGLE);
    move_ok    = (state == PAUSE || state == RUN) && (key == K_MOVE);
    run_entry  = (state != RUN) && (state_nxt == RUN);
    reload_div = run_entry || (tick && state_nxt == RUN);
    row_nxt    = row_r;
    col_nxt    = col_r;
    if (move_ok && (bus.key_up != bus.key_down))
      row_nxt = bus.key_up ? ((row_r == '0) ? ROW_MAX : row_r - 1'b1)
                           : ((row_r == ROW_MAX) ? '0 : row_r + 1'b1);
    if (move_ok && (bus.key_left != bus.key_right))
      col_nxt = bus.key_left ? ((col_r == '0) ? COL_MAX : col_r - 1'b1)
                             : ((col_r == COL_MAX) ? '0 : col_r + 1'b1);
  end

  always_ff @(posedge Clock) begin
    if (reset) begin
      div       <= '0;
      tog_q     <= 1'b0;
      step_r    <= 1'b0;
      clear_r   <= 1'b0;
      seed_r    <= 1'b0;
      srow_r    <= '0;
      scol_r    <= '0;
      row_r     <= '0;
      col_r     <= '0;
      running_r <= 1'b0;
      gen_r     <= '0;
    end else begin
      if (reload_div)         div <= reload;
      else if (state == RUN)  div <= div - 1'b1;
      tog_q     <= seed_nxt;
      step_r    <= step_nxt;
      clear_r   <= clear_nxt;
      seed_r    <= tog_q;
      // cursor cannot have moved on the toggle edge, so it is still the toggled cell
      if (tog_q) begin
        srow_r <= row_r;
        scol_r <= col_r;
      end
      row_r     <= row_nxt;
      col_r     <= col_nxt;
      running_r <= (state_nxt == RUN);
      if (clear_r)                     gen_r <= '0;
      else if (step_r && gen_r != '1)  gen_r <= gen_r + 1'b1;
    end
  end

`ifdef LIFE_STILL_DETECT_EN
  // chk marks the cycle in which grid_changed answers the previous step_en
  always_ff @(posedge Clock) begin
    if (reset) begin
      chk      <= 1'b0;
      stable_r <= 1'b0;
    end else begin
      chk <= step_r;
      if (state == RUN && still_hit && key != K_CLEAR && key != K_RUN) stable_r <= 1'b1;
      else if (step_r || clear_r || run_entry)                         stable_r <= 1'b0;
    end
  end
  assign bus.stable = stable_r;
`endif

  assign bus.step_en     = step_r;
  assign bus.clear_cells = clear_r;
  assign bus.seed_we     = seed_r;
  assign bus.seed_row    = srow_r;
  assign bus.seed_col    = scol_r;
  assign bus.cursor_row  = row_r;
  assign bus.cursor_col  = col_r;
  assign bus.running     = running_r;
  assign bus.gen_count   = gen_r;
endmodule

// File: tb/tb_life_sequencer.sv
// Bench for life_sequencer: event-time reference model compared every cycle,
// directed scenarios with literal expectations, then randomized key traffic.
module tb_life_sequencer;
  localparam int ROWS = 16, COLS = 16, TP = 8, GW = 4;
  localparam int GMAX = (1 << GW) - 1;

  logic Clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0, errors = 0;

  life_sequencer_if #(.ROWS(ROWS), .COLS(COLS), .GEN_W(GW)) bus ();
  life_sequencer #(.ROWS(ROWS), .COLS(COLS), .TICK_PERIOD(TP), .GEN_W(GW)) dut (
    .Clock(Clock), .reset(reset), .bus(bus));

  always #5 Clock = ~Clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: absolute edge times instead of a countdown; strobes are
  // scheduled one edge ahead as "pending" events.
  bit m_on = 0;
  int cyc = 0;
  bit m_run, m_busy, p_step, p_clear, p_seed, m_step, m_clear, m_seed, m_step_old, m_stable;
  int m_row, m_col, m_srow, m_scol, m_gen, m_next;

  always @(posedge Clock) begin
    int p, top;
    bit was_run, chk, entry, n_step, n_clear, n_seed;
`ifdef LIFE_STILL_DETECT_EN
    bit frc;
`endif
    cyc++;
    if (reset) begin
      {m_run, m_busy, p_step, p_clear, p_seed, m_step, m_clear, m_seed, m_step_old, m_stable} = '0;
      m_row = 0; m_col = 0; m_srow = 0; m_scol = 0; m_gen = 0; m_next = 0;
      m_on = 1;
    end else begin
      p = TP >> bus.speed;
      if (m_clear) m_gen = 0;
      else if (m_step && m_gen < GMAX) m_gen++;
      chk = m_step_old;
      m_step_old = m_step;
      was_run = m_run;
      entry = 0;
      n_step = p_step; n_clear = p_clear; n_seed = p_seed;
      p_step = 0; p_clear = 0; p_seed = 0;
      if (n_seed) begin m_srow = m_row; m_scol = m_col; end
      top = bus.key_clear ? 1 : bus.key_run ? 2 : bus.key_step ? 3 : bus.key_toggle ? 4 :
            (bus.key_up || bus.key_down || bus.key_left || bus.key_right) ? 5 : 0;
      if (m_busy) m_busy = 0;
      else case (top)
        1: begin p_clear = 1; m_busy = 1; m_run = 0; end
        2: if (m_run) m_run = 0;
           else begin m_run = 1; entry = 1; m_next = cyc + p; end
        3: if (!m_run) begin p_step = 1; m_busy = 1; end
        4: if (!m_run) p_seed = 1;
        5: begin
          if (bus.key_up && !bus.key_down)    m_row = (m_row + ROWS - 1) % ROWS;
          if (bus.key_down && !bus.key_up)    m_row = (m_row + 1) % ROWS;
          if (bus.key_left && !bus.key_right) m_col = (m_col + COLS - 1) % COLS;
          if (bus.key_right && !bus.key_left) m_col = (m_col + 1) % COLS;
        end
        default: ;
      endcase
`ifdef LIFE_STILL_DETECT_EN
      frc = was_run && m_run && chk && !bus.grid_changed;
      if (frc) m_run = 0;
`endif
      if (was_run && m_run && cyc == m_next) begin
        n_step = 1;
        m_next = cyc + p;
      end
`ifdef LIFE_STILL_DETECT_EN
      if (frc) m_stable = 1;
      else if (m_step || m_clear || entry) m_stable = 0;
`endif
      m_step = n_step; m_clear = n_clear; m_seed = n_seed;
    end
  end

  always @(posedge Clock) begin
    #1;
    if (m_on) begin
      check("step_en",     bus.step_en,     m_step);
      check("clear_cells", bus.clear_cells, m_clear);
      check("seed_we",     bus.seed_we,     m_seed);
      check("seed_row",    bus.seed_row,    m_srow);
      check("seed_col",    bus.seed_col,    m_scol);
      check("cursor_row",  bus.cursor_row,  m_row);
      check("cursor_col",  bus.cursor_col,  m_col);
      check("running",     bus.running,     m_run);
      check("gen_count",   bus.gen_count,   m_gen);
`ifdef LIFE_STILL_DETECT_EN
      check("stable",      bus.stable,      m_stable);
`endif
    end
  end

  // key vector order: clear run step toggle up down left right
  task automatic set_keys(input logic [7:0] k);
    {bus.key_clear, bus.key_run, bus.key_step, bus.key_toggle,
     bus.key_up, bus.key_down, bus.key_left, bus.key_right} = k;
  endtask

  // returns at the negedge right after the sampling edge
  task automatic press(input logic [7:0] k);
    @(negedge Clock); set_keys(k);
    @(negedge Clock); set_keys(8'h00);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge Clock);
  endtask

  task automatic do_reset();
    @(negedge Clock); reset = 1'b1;
    idle(2);
    reset = 1'b0;
  endtask

  initial begin
    int first, second, npulse, nseed;
    set_keys(8'h00);
    bus.speed = 2'd0;
`ifdef LIFE_STILL_DETECT_EN
    bus.grid_changed = 1'b1;
`endif
    idle(2);
    reset = 1'b0;
    check("reset running", bus.running, 0);
    check("reset gen", bus.gen_count, 0);
    check("reset cursor", {bus.cursor_row, bus.cursor_col}, 0);

    // free run at speed 0: pulses at 8, 16, 24
    press(8'h40);
    check("run entry running", bus.running, 1);
    first = -1; npulse = 0; second = -1;
    for (int i = 1; i <= 24; i++) begin
      @(negedge Clock);
      if (bus.step_en) begin
        npulse++;
        if (first < 0) first = i; else if (second < 0) second = i;
      end
    end
    check("run first pulse", first, 8);
    check("run second pulse", second, 16);
    check("run pulse count", npulse, 3);
    idle(1);
    check("run gen after 3", bus.gen_count, 3);
    press(8'h40);

    // single steps from pause
    press(8'h80);
    idle(2);
    check("clear gen", bus.gen_count, 0);
    npulse = 0;
    for (int s = 0; s < 3; s++) begin
      press(8'h20);
      for (int j = 0; j < 3; j++) begin
        @(negedge Clock);
        if (bus.step_en) npulse++;
      end
    end
    check("step pulse count", npulse, 3);
    check("step gen", bus.gen_count, 3);

    // cursor wrap and toggle
    do_reset();
    check("reset2 cursor", {bus.cursor_row, bus.cursor_col}, 0);
    press(8'h08);
    press(8'h02);
    check("wrap row", bus.cursor_row, 15);
    check("wrap col", bus.cursor_col, 15);
    press(8'h10);
    check("seed early", bus.seed_we, 0);
    @(negedge Clock);
    check("seed_we", bus.seed_we, 1);
    check("seed addr", {bus.seed_row, bus.seed_col}, {4'd15, 4'd15});
    @(negedge Clock);
    check("seed one cycle", bus.seed_we, 0);

    // toggle ignored while running
    press(8'h40);
    press(8'h10);
    nseed = 0;
    for (int j = 0; j < 3; j++) begin
      @(negedge Clock);
      if (bus.seed_we) nseed++;
    end
    check("no seed in run", nseed, 0);
    press(8'h40);

    // clear beats run on the same edge
    press(8'hC0);
    check("clear+run running", bus.running, 0);
    @(negedge Clock);
    check("clear strobe", bus.clear_cells, 1);
    @(negedge Clock);
    check("clear one cycle", bus.clear_cells, 0);
    check("clear+run gen", bus.gen_count, 0);

    // speed change mid-period: 8, then every 2
    press(8'h40);
    idle(3);
    bus.speed = 2'd2;
    first = -1; second = -1;
    for (int i = 4; i <= 11; i++) begin
      @(negedge Clock);
      if (bus.step_en) begin
        if (first < 0) first = i; else if (second < 0) second = i;
      end
    end
    check("speed old period", first, 8);
    check("speed new period", second, 10);
    press(8'h40);

    // saturation at period 1
    bus.speed = 2'd3;
    press(8'h40);
    idle(30);
    check("gen saturates", bus.gen_count, GMAX);
    press(8'h40);
    bus.speed = 2'd0;

    // reset mid-run
    press(8'h40);
    idle(7);
    @(negedge Clock); reset = 1'b1;
    @(negedge Clock);
    check("midrun reset running", bus.running, 0);
    check("midrun reset step", bus.step_en, 0);
    check("midrun reset gen", bus.gen_count, 0);
    reset = 1'b0;

`ifdef LIFE_STILL_DETECT_EN
    press(8'h40);
    npulse = 0;
    for (int i = 0; i < 40 && npulse == 0; i++) begin
      @(negedge Clock);
      if (bus.step_en) npulse = 1;
    end
    check("still step seen", npulse, 1);
    @(negedge Clock); bus.grid_changed = 1'b0;
    @(negedge Clock); bus.grid_changed = 1'b1;
    check("still running", bus.running, 0);
    check("still stable", bus.stable, 1);
    press(8'h40);
    check("still cleared by run", bus.stable, 0);
    press(8'h40);
`endif

    // randomized traffic against the model
    for (int n = 0; n < 4000; n++) begin
      @(negedge Clock);
      reset = ($urandom_range(0, 599) == 0);
      bus.key_clear  = ($urandom_range(0, 89) == 0);
      bus.key_run    = ($urandom_range(0, 29) == 0);
      bus.key_step   = ($urandom_range(0, 11) == 0);
      bus.key_toggle = ($urandom_range(0, 9) == 0);
      bus.key_up     = ($urandom_range(0, 7) == 0);
      bus.key_down   = ($urandom_range(0, 7) == 0);
      bus.key_left   = ($urandom_range(0, 7) == 0);
      bus.key_right  = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 49) == 0) bus.speed = 2'($urandom_range(0, 3));
`ifdef LIFE_STILL_DETECT_EN
      bus.grid_changed = ($urandom_range(0, 5) != 0);
`endif
    end
    @(negedge Clock);
    reset = 1'b0;
    set_keys(8'h00);
    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/life_sequencer.md
# life_sequencer

Generation controller for the Game of Life cell array. Decides when the array advances one generation (free-run at a selectable rate or single-step), clears it, and lets the user seed cells through a wrapping cursor while paused. Sits between the debounced/edge-detected key inputs and the cell array; every cell's update enable, clear and seed-write strobes come from here.

## Interface
- ROWS, 16, array rows; cursor row range 0..ROWS-1
- COLS, 16, array columns; cursor column range 0..COLS-1
- TICK_PERIOD, 25_000_000, clocks per generation at speed 0; must be ≥ 8
- GEN_W, 16, generation counter width
- Clock  in  1  system clock
- reset  in  1  synchronous, active-high
- key_run  in  1  one-cycle pulse; toggles RUN/PAUSE
- key_step  in  1  one-cycle pulse; single generation while paused
- key_clear  in  1  one-cycle pulse; clear array, zero generation count
- key_toggle  in  1  one-cycle pulse; invert cell under cursor while paused
- key_up, key_down, key_left, key_right  in  1 each  one-cycle cursor moves
- speed  in  2  rate select; period = TICK_PERIOD >> speed
- step_en  out  1  one-cycle pulse; array computes next generation
- clear_cells  out  1  one-cycle pulse; array forces all cells dead
- seed_we  out  1  one-cycle pulse; array inverts cell (seed_row, seed_col)
- seed_row  out  $clog2(ROWS)  seed address row
- seed_col  out  $clog2(COLS)  seed address column
- cursor_row, cursor_col  out  as above  current cursor, for display
- running  out  1  high in RUN
- gen_count  out  GEN_W  generations since last clear, saturating

## Operation
- States: PAUSE, RUN, STEP, CLEAR. Reset → PAUSE.
- Key priority on the same edge: key_clear > key_run > key_step > key_toggle > cursor moves. Lower-priority keys on that edge are dropped.
- PAUSE: key_clear → CLEAR; key_run → RUN (divider reloaded with period-1); key_step → STEP; key_toggle → seed_we pulse with seed_row/col = cursor; cursor keys move cursor.
- STEP: one cycle; step_en=1, then → PAUSE. Keys arriving in STEP are dropped.
- RUN: divider counts down each clock; at 0 it pulses step_en and reloads period-1 using the speed value sampled at reload. key_run → PAUSE (divider halts, value held irrelevant); key_clear → CLEAR; key_step, key_toggle ignored; cursor keys still move cursor.
- CLEAR: one cycle; clear_cells=1, gen_count←0, then → PAUSE (running drops even if previously RUN).
- Cursor: up/down adjust row, left/right adjust column, wrap-around (row 0 up → ROWS-1, COLS-1 right → 0). Simultaneous up+down (or left+right) → no move on that axis; row and column moves on the same edge both apply.
- gen_count increments on every step_en; saturates at all-ones, never wraps.

## Timing
- All outputs registered. Reset values: step_en=0, clear_cells=0, seed_we=0, seed_row=0, seed_col=0, cursor 0,0, running=0, gen_count=0.
- Key pulse sampled at edge N → corresponding strobe high from edge N+1 to N+2 (one cycle).
- key_run at edge N → running=1 after edge N; first step_en exactly period clocks after edge N, then every period clocks.
- gen_count reflects a step_en one cycle after the strobe.
- Speed change mid-period takes effect at next reload; current period finishes at old rate.
- reset mid-RUN: all outputs return to reset values on the following edge; no partial strobe.

## Configuration
- LIFE_STILL_DETECT_EN defined: extra input grid_changed (1 bit, valid the cycle after step_en) and output stable (1 bit, reset 0). In RUN, a step whose grid_changed=0 forces → PAUSE and sets stable=1; stable clears on any step_en, clear or run entry.
- Undefined: no grid_changed/stable ports; RUN continues until key_run/key_clear.

## Test plan
- Reset, TICK_PERIOD=8, speed=0, key_run → step_en pulses at 8, 16, 24 cycles; gen_count 1,2,3; running=1.
- Paused, key_step ×3 spaced → three single-cycle step_en, gen_count=3; key_step during RUN → no extra pulse.
- Cursor at 0,0, key_up then key_left → cursor 15,15; key_toggle → seed_we one cycle with seed_row=15, seed_col=15; key_toggle in RUN → no seed_we.
- key_clear and key_run same edge while paused → clear_cells one cycle, gen_count=0, running stays 0.
- speed=2 mid-period at TICK_PERIOD=16 → current period ends at 16, following periods 4.
- LIFE_STILL_DETECT_EN: in RUN, grid_changed=0 after a step → running=0, stable=1; key_run → stable=0.
